// File: rtl/adc_pipe_decimator.sv
// adc_pipe_decimator
//   Consumes the pipelined ADC encoder's output code, drops the encoder's
//   pipeline warm-up samples, and averages 2**LOG2_AVG codes per result.
//   Results go through a small output FIFO and leave on a valid/ready
//   handshake.
//
//   Optional feature macro: ADC_DEC_ROUND_EN
//     defined   : mean = min((sum + 2**(LOG2_AVG-1)) >> LOG2_AVG, 2**NUM_BITS-1)
//     undefined : mean = sum >> LOG2_AVG
//     LOG2_AVG=0 is a pass-through in both modes.
//
// Ports
//   clock_i    in  clock, rising edge
//   reset_ni   in  synchronous active-low reset
//   enable_i   in  decimator enable; low clears accumulation state
//   sample_i   in  strobe: d_i carries a new conversion result
//   d_i        in  [NUM_BITS-1:0] encoder code
//   data_o     out [NUM_BITS-1:0] head-of-FIFO average (0 when empty)
//   valid_o    out FIFO not empty
//   ready_i    in  consumer accepts data_o when valid_o && ready_i
//   level_o    out [$clog2(FIFO_DEPTH):0] FIFO occupancy
//   overflow_o out sticky: an average was dropped on a full FIFO
module adc_pipe_decimator #(
  parameter int NUM_BITS   = 3,
  parameter int LOG2_AVG   = 2,
  parameter int WARMUP     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic                          enable_i,
  input  logic                          sample_i,
  input  logic [NUM_BITS-1:0]           d_i,
  output logic [NUM_BITS-1:0]           data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overflow_o
);

  localparam int AW = NUM_BITS + LOG2_AVG;
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam int WW = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_ACC} state_t;

  state_t               state_q, state_d;
  logic [WW-1:0]        warm_q, warm_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [NUM_BITS-1:0]  mem_q [FIFO_DEPTH];
  logic [NUM_BITS-1:0]  mem_d [FIFO_DEPTH];
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic                 ovf_q, ovf_d;

  logic                 push_req;
  logic                 push_ok;
  logic                 pop;
  logic                 valid;
  logic                 full;
  logic [AW:0]          sum_ext;
  logic [NUM_BITS-1:0]  mean;

  // Accumulation control
  always_comb begin
    state_d  = state_q;
    warm_d   = warm_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    push_req = 1'b0;
    if (!enable_i) begin
      state_d = S_IDLE;
      warm_d  = WW'(WARMUP);
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = (WARMUP == 0) ? S_ACC : S_WARM;
        S_WARM: begin
          if (sample_i) begin
            warm_d = warm_q - WW'(1);
            if (warm_q == WW'(1)) state_d = S_ACC;
          end
        end
        S_ACC: begin
          if (sample_i) begin
            if (cnt_q == CNT_LAST) begin
              push_req = 1'b1;
              acc_d    = '0;
              cnt_d    = '0;
            end else begin
              acc_d = acc_q + AW'(d_i);
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Final sum includes the current strobe, so the mean is ready at the push edge
  assign sum_ext = {1'b0, acc_q} + (AW + 1)'(d_i);

`ifdef ADC_DEC_ROUND_EN
  localparam int HALF = (LOG2_AVG > 0) ? (1 << (LOG2_AVG - 1)) : 0;
  localparam int MAXV = (1 << NUM_BITS) - 1;
  logic [AW:0] rnd_sh;
  always_comb begin
    rnd_sh = (sum_ext + (AW + 1)'(HALF)) >> LOG2_AVG;
    if (rnd_sh > (AW + 1)'(MAXV)) mean = '1;
    else                          mean = rnd_sh[NUM_BITS-1:0];
  end
`else
  assign mean = NUM_BITS'(sum_ext >> LOG2_AVG);
`endif

  // Output FIFO
  assign valid   = (level_q != '0);
  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign pop     = valid && ready_i;
  assign push_ok = push_req && (!full || pop);

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    ovf_d   = ovf_q;
    if (push_ok) begin
      mem_d[wr_q] = mean;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    if (push_req && !push_ok) ovf_d = 1'b1;
    level_d = level_q + LW'(push_ok) - LW'(pop);
  end

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      warm_q  <= WW'(WARMUP);
      cnt_q   <= '0;
      acc_q   <= '0;
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid;
  assign data_o     = valid ? mem_q[rd_q] : '0;
  assign level_o    = level_q;
  assign overflow_o = ovf_q;

endmodule
